// File: rtl/multiexp_pnt_scl_streamer_pkg.sv
// Shared definitions for the multiexp point/scalar streamer: FSM state
// encoding, streamer constants and the default G2 entry types.
package multiexp_pnt_scl_streamer_pkg;

   // Montgomery-form Jacobian G2 point: three Fp2 coordinates of 2x256 bits.
   typedef logic [1535:0] fp2_jb_point_t;
   // Scalar field element.
   typedef logic [255:0]  fe_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } streamer_state_e;

   localparam int MULTIEXP_STREAMER_CTL_BITS   = 8;
   localparam int MULTIEXP_STREAMER_FIFO_DEPTH = 2;

endpackage

// File: rtl/multiexp_pnt_scl_streamer_pnt_scl_buf.sv
// Entry buffer for the point/scalar streamer: simple dual-port RAM with one
// write port and one read port; read data is registered (1-cycle latency).
module multiexp_pnt_scl_streamer_pnt_scl_buf #(
   parameter int ENT_BITS = 32,
   parameter int MAX_IN   = 1024,
   localparam int AW      = $clog2(MAX_IN)
) (
   input  logic                i_clk,
   input  logic                i_we,
   input  logic [AW-1:0]       i_waddr,
   input  logic [ENT_BITS-1:0] i_wdat,
   input  logic                i_re,
   input  logic [AW-1:0]       i_raddr,
   output logic [ENT_BITS-1:0] o_rdat
);

   logic [ENT_BITS-1:0] mem [MAX_IN];

   // Write port: one entry per accepted load beat.
   always_ff @(posedge i_clk) begin
      if (i_we) mem[i_waddr] <= i_wdat;
   end

   // Read port: registered output, holds its value when no read is issued.
   always_ff @(posedge i_clk) begin
      if (i_re) o_rdat <= mem[i_raddr];
   end

endmodule

// File: rtl/multiexp_pnt_scl_streamer.sv
// Point/scalar source streamer for the G2 multiexp core. Buffers one host
// burst of {point, scalar} entries, then replays the set NUM_PASSES times.
// Optional feature macro: MULTIEXP_STREAMER_PASS_CTL_EN puts the pass
// counter on the output ctl field; otherwise ctl is zero.
module multiexp_pnt_scl_streamer
   import multiexp_pnt_scl_streamer_pkg::*;
#(
   parameter type FP2_TYPE   = fp2_jb_point_t,
   parameter type FE_TYPE    = fe_t,
   parameter int  MAX_IN     = 1024,
   parameter int  NUM_PASSES = $bits(FE_TYPE),
   parameter int  ENT_BITS   = $bits(FP2_TYPE) + $bits(FE_TYPE),
   parameter int  DAT_BYTS   = (ENT_BITS + 7) / 8,
   parameter int  MOD_BITS   = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   // host load stream
   input  logic [DAT_BYTS*8-1:0]                 i_load_dat,
   input  logic                                  i_load_val,
   input  logic                                  i_load_sop,
   input  logic                                  i_load_eop,
   input  logic                                  i_load_err,
   input  logic [MOD_BITS-1:0]                   i_load_mod,
   input  logic [MULTIEXP_STREAMER_CTL_BITS-1:0] i_load_ctl,
   output logic                                  o_load_rdy,
   // core point/scalar stream
   output logic [DAT_BYTS*8-1:0]                 o_pnt_scl_dat,
   output logic                                  o_pnt_scl_val,
   output logic                                  o_pnt_scl_sop,
   output logic                                  o_pnt_scl_eop,
   output logic                                  o_pnt_scl_err,
   output logic [MOD_BITS-1:0]                   o_pnt_scl_mod,
   output logic [MULTIEXP_STREAMER_CTL_BITS-1:0] o_pnt_scl_ctl,
   input  logic                                  i_pnt_scl_rdy,
   // status
   output logic [63:0]                           o_num_in,
   output logic                                  o_busy,
   output logic                                  o_ovf
);

   localparam int AW  = $clog2(MAX_IN);
   localparam int CW  = AW + 1;
   localparam int PW  = $clog2(NUM_PASSES) + 1;
   localparam int CB  = MULTIEXP_STREAMER_CTL_BITS;
   localparam int FW  = CB + 2 + ENT_BITS;
   localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);

   streamer_state_e state, state_nxt;

   logic [CW-1:0] wr_ptr, wr_idx, count, cnt_nxt, rd_ptr;
   logic [PW-1:0] pass_cnt;
   logic          acc, wr_ok, wr_en, ovf_set, cnt_ld;

   logic          rd_en, space, pop;
   logic          sop_p0, eop_p0, last_p0;
   logic [CB-1:0] ctl_p0;
   logic [2:0]    credit_p0;

   logic                vld_p1, sop_p1, eop_p1;
   logic [CB-1:0]       ctl_p1;
   logic [ENT_BITS-1:0] ent_p1;

   logic [FW-1:0] fifo_mem [MULTIEXP_STREAMER_FIFO_DEPTH];
   logic          fifo_wr_idx, fifo_rd_idx;
   logic [1:0]    fifo_cnt;
   logic [ENT_BITS-1:0] out_ent;

   // Load-side sideband fields carry nothing the buffer needs.
   logic unused_load;
   assign unused_load = ^{i_load_err, i_load_mod, i_load_ctl, i_load_dat};

   // ---- stage p0: read issue ----
   assign pop       = o_pnt_scl_val & i_pnt_scl_rdy;
   assign credit_p0 = 3'(fifo_cnt) + 3'(vld_p1);
   // A read may issue only if the FIFO can hold it once in-flight reads land.
   assign space     = credit_p0 < (3'(MULTIEXP_STREAMER_FIFO_DEPTH) + 3'(pop));
   assign sop_p0    = (rd_ptr == '0);
   assign eop_p0    = (rd_ptr == count - CW'(1));
   assign last_p0   = eop_p0 && (pass_cnt == LAST_PASS);

`ifdef MULTIEXP_STREAMER_PASS_CTL_EN
   assign ctl_p0 = CB'(pass_cnt);
`else
   assign ctl_p0 = '0;
`endif

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // FSM next state, load handshake, write control and read issue.
   always_comb begin
      state_nxt  = state;
      o_load_rdy = 1'b0;
      acc        = 1'b0;
      wr_idx     = '0;
      wr_ok      = 1'b0;
      wr_en      = 1'b0;
      ovf_set    = 1'b0;
      cnt_ld     = 1'b0;
      cnt_nxt    = count;
      rd_en      = 1'b0;
      case (state)
         ST_IDLE, ST_LOAD: begin
            o_load_rdy = i_rst_n;
            acc        = i_load_val & i_rst_n;
            wr_idx     = i_load_sop ? '0 : wr_ptr;
            wr_ok      = wr_idx < CW'(MAX_IN);
            // In IDLE only a sop beat starts a load; other beats are dropped.
            if (acc && (i_load_sop || state == ST_LOAD)) begin
               wr_en   = wr_ok;
               ovf_set = ~wr_ok;
               if (i_load_eop) begin
                  cnt_ld    = 1'b1;
                  cnt_nxt   = wr_ok ? wr_idx + CW'(1) : CW'(MAX_IN);
                  state_nxt = ST_STREAM;
               end else begin
                  state_nxt = ST_LOAD;
               end
            end
         end
         ST_STREAM: begin
            rd_en = space;
            if (space && last_p0) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!vld_p1 && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop)))
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Write pointer follows accepted beats; sop restarts at address 0.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)   wr_ptr <= '0;
      else if (wr_en) wr_ptr <= wr_idx + CW'(1);
   end

   // Entry count latched on the load's eop beat.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)    count <= '0;
      else if (cnt_ld) count <= cnt_nxt;
   end

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)     o_ovf <= 1'b0;
      else if (ovf_set) o_ovf <= 1'b1;
   end

   // Read pointer and pass counter walk the buffer only while streaming.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || state != ST_STREAM) begin
         rd_ptr   <= '0;
         pass_cnt <= '0;
      end else if (rd_en) begin
         if (eop_p0) begin
            rd_ptr   <= '0;
            pass_cnt <= pass_cnt + PW'(1);
         end else begin
            rd_ptr   <= rd_ptr + CW'(1);
         end
      end
   end

   multiexp_pnt_scl_streamer_pnt_scl_buf #(
      .ENT_BITS (ENT_BITS),
      .MAX_IN   (MAX_IN)
   ) u_buf (
      .i_clk   (i_clk),
      .i_we    (wr_en),
      .i_waddr (wr_idx[AW-1:0]),
      .i_wdat  (i_load_dat[ENT_BITS-1:0]),
      .i_re    (rd_en),
      .i_raddr (rd_ptr[AW-1:0]),
      .o_rdat  (ent_p1)
   );

   // ---- stage p1: buffer read data, pushed into the prefetch FIFO ----
   // Read-valid tracks the in-flight buffer read.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) vld_p1 <= 1'b0;
      else          vld_p1 <= rd_en;
   end

   // Beat markers travel with the read alongside the RAM latency.
   always_ff @(posedge i_clk) begin
      if (rd_en) begin
         sop_p1 <= sop_p0;
         eop_p1 <= eop_p0;
         ctl_p1 <= ctl_p0;
      end
   end

   // Prefetch FIFO occupancy and pointers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         fifo_cnt    <= '0;
         fifo_wr_idx <= 1'b0;
         fifo_rd_idx <= 1'b0;
      end else begin
         fifo_cnt <= fifo_cnt + 2'(vld_p1) - 2'(pop);
         if (vld_p1) fifo_wr_idx <= ~fifo_wr_idx;
         if (pop)    fifo_rd_idx <= ~fifo_rd_idx;
      end
   end

   // Prefetch FIFO storage; the head slot is never overwritten while held.
   always_ff @(posedge i_clk) begin
      if (vld_p1) fifo_mem[fifo_wr_idx] <= {ctl_p1, sop_p1, eop_p1, ent_p1};
   end

   // ---- output: FIFO head ----
   assign {o_pnt_scl_ctl, o_pnt_scl_sop, o_pnt_scl_eop, out_ent} = fifo_mem[fifo_rd_idx];
   assign o_pnt_scl_dat = (DAT_BYTS*8)'(out_ent);
   assign o_pnt_scl_val = (fifo_cnt != 2'd0);
   assign o_pnt_scl_err = 1'b0;
   assign o_pnt_scl_mod = '0;
   assign o_num_in      = 64'(count);
   assign o_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_multiexp_pnt_scl_streamer.sv
// Scoreboard bench for multiexp_pnt_scl_streamer with small entry types.
module tb_multiexp_pnt_scl_streamer;

   localparam int MAX_IN = 8;
   localparam int NP     = 8;
   localparam int DB     = 4;
   localparam int MB     = 2;
   typedef logic [41:0] beat_t;   // {ctl, sop, eop, dat}

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   ld_dat = '0;
   logic          ld_val = 1'b0, ld_sop = 1'b0, ld_eop = 1'b0;
   logic          ld_rdy;
   logic [31:0]   o_dat;
   logic          o_val, o_sop, o_eop, o_err;
   logic [MB-1:0] o_mod;
   logic [7:0]    o_ctl;
   logic          rdy = 1'b1;
   logic [63:0]   num_in;
   logic          busy, ovf;

   always #5 clk = ~clk;

   multiexp_pnt_scl_streamer #(
      .FP2_TYPE   (logic [23:0]),
      .FE_TYPE    (logic [7:0]),
      .MAX_IN     (MAX_IN),
      .NUM_PASSES (NP)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_load_dat    (ld_dat),
      .i_load_val    (ld_val),
      .i_load_sop    (ld_sop),
      .i_load_eop    (ld_eop),
      .i_load_err    (1'b0),
      .i_load_mod    ({MB{1'b0}}),
      .i_load_ctl    (8'h00),
      .o_load_rdy    (ld_rdy),
      .o_pnt_scl_dat (o_dat),
      .o_pnt_scl_val (o_val),
      .o_pnt_scl_sop (o_sop),
      .o_pnt_scl_eop (o_eop),
      .o_pnt_scl_err (o_err),
      .o_pnt_scl_mod (o_mod),
      .o_pnt_scl_ctl (o_ctl),
      .i_pnt_scl_rdy (rdy),
      .o_num_in      (num_in),
      .o_busy        (busy),
      .o_ovf         (ovf)
   );

   int    n_chk = 0, n_pass = 0;
   beat_t exp_q[$];
   int    cyc = 0, pops = 0, first_cyc = 0, last_cyc = 0;
   bit    rnd_rdy = 1'b0;
   bit    stalled = 1'b0;
   beat_t held;
   logic [31:0] ents[$];
   beat_t dut_beat;

   assign dut_beat = {o_ctl, o_sop, o_eop, o_dat};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   // Reference beat: which entry, which pass, and where it sits in the pass.
   function automatic beat_t mk(input int p, input bit s, input bit e, input logic [31:0] d);
      logic [7:0] c;
`ifdef MULTIEXP_STREAMER_PASS_CTL_EN
      c = 8'(p);
`else
      c = 8'h00;
`endif
      return {c, s, e, d};
   endfunction

   always @(posedge clk) cyc++;

   // Output ready: either always high or a coin toss per cycle.
   always @(posedge clk) begin
      #1;
      rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: compare every handshaken beat, and check stability while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) chk("hold_stable", {o_val, dut_beat}, {1'b1, held});
         if (o_val && rdy) begin
            chk("beat_side", {o_err, o_mod}, '0);
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL beat_unexpected: got %0h required none", dut_beat);
            end else begin
               chk("beat", dut_beat, exp_q.pop_front());
            end
            pops++;
            if (pops == 1) first_cyc = cyc;
            last_cyc = cyc;
            stalled = 1'b0;
         end else if (o_val) begin
            stalled = 1'b1;
            held = dut_beat;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   task automatic send(input logic [31:0] d, input bit s, input bit e);
      ld_dat = d; ld_val = 1'b1; ld_sop = s; ld_eop = e;
      @(negedge clk);
      chk("load_rdy", ld_rdy, 1);
      @(posedge clk); #1;
      ld_val = 1'b0; ld_sop = 1'b0; ld_eop = 1'b0;
   endtask

   // Load n entries (optionally preceded by a stray non-sop beat and/or an
   // aborted partial load of 'pre' beats) and queue the expected replay.
   task automatic run_load(input int n, input bit junk, input int pre);
      int ne;
      ne = (n > MAX_IN) ? MAX_IN : n;
      ents.delete();
      for (int i = 0; i < n; i++) ents.push_back($urandom);
      pops = 0;
      for (int p = 0; p < NP; p++)
         for (int i = 0; i < ne; i++)
            exp_q.push_back(mk(p, i == 0, i == ne - 1, ents[i]));
      @(posedge clk); #1;
      if (junk) send($urandom, 1'b0, 1'b0);
      for (int i = 0; i < pre; i++) send($urandom, i == 0, 1'b0);
      for (int i = 0; i < n; i++) send(ents[i], i == 0, i == n - 1);
      @(negedge clk);
      chk("num_in", num_in, 64'(ne));
      chk("busy_on", busy, 1);
      chk("lat_c1", o_val, 0);
      @(negedge clk);
      chk("lat_c2", o_val, 0);
      @(negedge clk);
      chk("lat_c3", o_val, 1);
   endtask

   task automatic wait_done(input int total);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 4000) begin
         @(negedge clk); #2;
         t++;
      end
      chk("stream_done", exp_q.size(), 0);
      chk("busy_last", busy, 1);
      @(negedge clk); #1;
      chk("busy_off", busy, 0);
      if (!rnd_rdy) chk("no_gap_span", last_cyc - first_cyc + 1, total);
      exp_q.delete();
   endtask

   initial begin
      int t;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_val", o_val, 0);
      chk("rst_busy", busy, 0);
      chk("rst_num_in", num_in, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_load_rdy", ld_rdy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("load_rdy_after_rst", ld_rdy, 1);

      // basic 4-entry replay, stray non-sop beat dropped in IDLE
      rnd_rdy = 1'b0;
      run_load(4, 1'b1, 0);
      wait_done(4 * NP);
      // single entry: sop&eop on every beat
      run_load(1, 1'b0, 0);
      wait_done(NP);
      // second sop inside LOAD restarts at address 0
      run_load(3, 1'b0, 2);
      wait_done(3 * NP);
      // exactly full buffer, no overflow
      run_load(MAX_IN, 1'b0, 0);
      wait_done(MAX_IN * NP);
      chk("ovf_full_clear", ovf, 0);
      // backpressure with random ready
      rnd_rdy = 1'b1;
      run_load(4, 1'b0, 0);
      wait_done(4 * NP);
      run_load(2 + $urandom_range(0, 5), 1'b0, 0);
      wait_done(0);
      run_load(1, 1'b0, 0);
      wait_done(NP);
      rnd_rdy = 1'b0;
      // overflow: 10 entries into an 8-entry buffer
      run_load(10, 1'b0, 0);
      wait_done(MAX_IN * NP);
      chk("ovf_set", ovf, 1);

      // reset during pass 3
      run_load(4, 1'b0, 0);
      t = 0;
      while (pops < 13 && t < 500) begin
         @(negedge clk); #2;
         t++;
      end
      chk("reach_pass3", pops >= 13, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_load_rdy", ld_rdy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("rst_mid_val", o_val, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_num_in", num_in, 0);
      chk("rst_mid_ovf", ovf, 0);
      repeat (3) @(negedge clk);
      chk("rst_mid_quiet", o_val, 0);
      run_load(2, 1'b0, 0);
      wait_done(2 * NP);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
